// File: rtl/imm_gen_pipe.sv
// Registered ID/EX immediate generator with stall/flush handling and a PFX prefix instruction.
// Optional macro IMM_GEN_ADDI_SEXT_EN: when defined, addi sign-extends its short immediate.
module imm_gen_pipe #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int IMM_W  = 3,
    parameter int JMP_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [OP_W-1:0]   opcode,
    input  logic [IMM_W-1:0]  immediate,
    input  logic [JMP_W-1:0]  jump_addr_short,
    output logic [DATA_W-1:0] extended,
    output logic              ext_valid,
    output logic              pfx_pending
);

    localparam logic [OP_W-1:0] OP_LW   = OP_W'(3'b000);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(3'b001);
    localparam logic [OP_W-1:0] OP_JUMP = OP_W'(3'b010);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(3'b100);
    localparam logic [OP_W-1:0] OP_PFX  = OP_W'(3'b111);

    logic [DATA_W-1:0] ext_q, ext_d;
    logic [JMP_W-1:0]  prefix_q, prefix_d;
    logic              vld_q, vld_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] base_val;
    logic [DATA_W-1:0] merged_val;

    // Unprefixed value: size casts truncate wide fields and zero/sign-fill narrow ones.
    always_comb begin
        base_val = '0;
        case (opcode)
            OP_LW, OP_SW: base_val = DATA_W'(immediate);
`ifdef IMM_GEN_ADDI_SEXT_EN
            OP_ADDI:      base_val = DATA_W'($signed(immediate));
`else
            OP_ADDI:      base_val = DATA_W'(immediate);
`endif
            OP_JUMP:      base_val = DATA_W'(jump_addr_short);
            default:      base_val = '0;
        endcase
    end

    // A pending prefix replaces extension entirely, addi included.
    always_comb begin
        merged_val = DATA_W'({prefix_q, {IMM_W{1'b0}}});
        case (opcode)
            OP_LW, OP_SW, OP_ADDI: merged_val = DATA_W'({prefix_q, immediate});
            OP_JUMP:               merged_val = DATA_W'({prefix_q, jump_addr_short});
            default:               merged_val = DATA_W'({prefix_q, {IMM_W{1'b0}}});
        endcase
    end

    always_comb begin
        ext_d    = ext_q;
        prefix_d = prefix_q;
        vld_d    = vld_q;
        pend_d   = pend_q;
        if (flush) begin
            vld_d  = 1'b0;
            pend_d = 1'b0;
        end else if (stall) begin
            vld_d  = vld_q;
        end else if (id_valid) begin
            if (opcode == OP_PFX) begin
                prefix_d = jump_addr_short;
                pend_d   = 1'b1;
                vld_d    = 1'b0;
            end else begin
                ext_d  = pend_q ? merged_val : base_val;
                vld_d  = 1'b1;
                pend_d = 1'b0;
            end
        end else begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q    <= '0;
            prefix_q <= '0;
            vld_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            ext_q    <= ext_d;
            prefix_q <= prefix_d;
            vld_q    <= vld_d;
            pend_q   <= pend_d;
        end
    end

    assign extended    = ext_q;
    assign ext_valid   = vld_q;
    assign pfx_pending = pend_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe; expected values are hand-computed constants.
module tb_imm_gen_pipe;

    logic       clk = 1'b0;
    logic       reset, id_valid, stall, flush;
    logic [2:0] opcode, immediate;
    logic [4:0] jump_addr_short;
    logic [7:0] extended;
    logic       ext_valid, pfx_pending;
    int         total = 0;
    int         bad   = 0;

`ifdef IMM_GEN_ADDI_SEXT_EN
    localparam logic [7:0] ADDI_101 = 8'hFD;
`else
    localparam logic [7:0] ADDI_101 = 8'h05;
`endif

    imm_gen_pipe dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .stall(stall), .flush(flush),
        .opcode(opcode), .immediate(immediate), .jump_addr_short(jump_addr_short),
        .extended(extended), .ext_valid(ext_valid), .pfx_pending(pfx_pending)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] imm, input logic [4:0] ja);
        id_valid = 1'b1; opcode = op; immediate = imm; jump_addr_short = ja;
        step();
        id_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            id_valid = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
            opcode = 3'($urandom); immediate = 3'($urandom); jump_addr_short = 5'($urandom);
            step();
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        total++; if (extended !== 8'h00) begin bad++; $display("FAIL reset_ext got=%h exp=00", extended); end
        total++; if (ext_valid !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", ext_valid); end
        total++; if (pfx_pending !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b exp=0", pfx_pending); end
        issue(3'b000, 3'b110, 5'b00000);
        total++; if (extended !== 8'h06) begin bad++; $display("FAIL lw_ext got=%h exp=06", extended); end
        total++; if (ext_valid !== 1'b1) begin bad++; $display("FAIL lw_vld got=%b exp=1", ext_valid); end
    endtask

    task automatic test_basic();
        issue(3'b100, 3'b101, 5'b00000);
        total++; if (extended !== ADDI_101) begin bad++; $display("FAIL addi_ext got=%h exp=%h", extended, ADDI_101); end
        issue(3'b010, 3'b000, 5'b10011);
        total++; if (extended !== 8'h13) begin bad++; $display("FAIL jump_ext got=%h exp=13", extended); end
        total++; if (ext_valid !== 1'b1) begin bad++; $display("FAIL jump_vld got=%b exp=1", ext_valid); end
        step();
        total++; if (ext_valid !== 1'b0) begin bad++; $display("FAIL idle_vld got=%b exp=0", ext_valid); end
        total++; if (extended !== 8'h13) begin bad++; $display("FAIL idle_ext got=%h exp=13", extended); end
    endtask

    task automatic test_prefix();
        issue(3'b111, 3'b000, 5'b10110);
        total++; if (ext_valid !== 1'b0) begin bad++; $display("FAIL pfx_vld got=%b exp=0", ext_valid); end
        total++; if (pfx_pending !== 1'b1) begin bad++; $display("FAIL pfx_pend got=%b exp=1", pfx_pending); end
        total++; if (extended !== 8'h13) begin bad++; $display("FAIL pfx_ext_hold got=%h exp=13", extended); end
        issue(3'b000, 3'b011, 5'b00000);
        total++; if (extended !== 8'hB3) begin bad++; $display("FAIL pfx_lw_ext got=%h exp=b3", extended); end
        total++; if (ext_valid !== 1'b1) begin bad++; $display("FAIL pfx_lw_vld got=%b exp=1", ext_valid); end
        total++; if (pfx_pending !== 1'b0) begin bad++; $display("FAIL pfx_lw_pend got=%b exp=0", pfx_pending); end
        issue(3'b001, 3'b001, 5'b00000);
        total++; if (extended !== 8'h01) begin bad++; $display("FAIL sw_ext got=%h exp=01", extended); end
    endtask

    task automatic test_stall();
        issue(3'b111, 3'b000, 5'b00001);
        stall = 1'b1; id_valid = 1'b1; opcode = 3'b100; immediate = 3'b111; jump_addr_short = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (extended !== 8'h01) begin bad++; $display("FAIL stall_ext[%0d] got=%h exp=01", i, extended); end
            total++; if (ext_valid !== 1'b0) begin bad++; $display("FAIL stall_vld[%0d] got=%b exp=0", i, ext_valid); end
            total++; if (pfx_pending !== 1'b1) begin bad++; $display("FAIL stall_pend[%0d] got=%b exp=1", i, pfx_pending); end
        end
        stall = 1'b0;
        step();
        id_valid = 1'b0;
        total++; if (extended !== 8'h0F) begin bad++; $display("FAIL stall_addi_ext got=%h exp=0f", extended); end
        total++; if (ext_valid !== 1'b1) begin bad++; $display("FAIL stall_addi_vld got=%b exp=1", ext_valid); end
        total++; if (pfx_pending !== 1'b0) begin bad++; $display("FAIL stall_addi_pend got=%b exp=0", pfx_pending); end
    endtask

    task automatic test_flush();
        issue(3'b111, 3'b000, 5'b11111);
        flush = 1'b1; stall = 1'b1; id_valid = 1'b1; opcode = 3'b000; immediate = 3'b101;
        step();
        flush = 1'b0; stall = 1'b0; id_valid = 1'b0;
        total++; if (pfx_pending !== 1'b0) begin bad++; $display("FAIL flush_pend got=%b exp=0", pfx_pending); end
        total++; if (ext_valid !== 1'b0) begin bad++; $display("FAIL flush_vld got=%b exp=0", ext_valid); end
        total++; if (extended !== 8'h0F) begin bad++; $display("FAIL flush_ext_hold got=%h exp=0f", extended); end
        issue(3'b000, 3'b010, 5'b00000);
        total++; if (extended !== 8'h02) begin bad++; $display("FAIL flush_lw_ext got=%h exp=02", extended); end
    endtask

    task automatic test_back_to_back();
        issue(3'b111, 3'b000, 5'b00010);
        issue(3'b111, 3'b000, 5'b00011);
        total++; if (pfx_pending !== 1'b1) begin bad++; $display("FAIL b2b_pend got=%b exp=1", pfx_pending); end
        issue(3'b000, 3'b000, 5'b00000);
        total++; if (extended !== 8'h18) begin bad++; $display("FAIL b2b_lw_ext got=%h exp=18", extended); end
        issue(3'b111, 3'b000, 5'b00001);
        issue(3'b010, 3'b000, 5'b00010);
        total++; if (extended !== 8'h22) begin bad++; $display("FAIL pfx_jump_ext got=%h exp=22", extended); end
        issue(3'b111, 3'b000, 5'b00101);
        issue(3'b110, 3'b111, 5'b11111);
        total++; if (extended !== 8'h28) begin bad++; $display("FAIL pfx_noimm_ext got=%h exp=28", extended); end
    endtask

    task automatic test_reset_mid_prefix();
        issue(3'b111, 3'b000, 5'b10101);
        reset = 1'b1; id_valid = 1'b1; opcode = 3'b000; immediate = 3'b111;
        step();
        reset = 1'b0; id_valid = 1'b0;
        total++; if (pfx_pending !== 1'b0) begin bad++; $display("FAIL rst_mid_pend got=%b exp=0", pfx_pending); end
        total++; if (extended !== 8'h00) begin bad++; $display("FAIL rst_mid_ext got=%h exp=00", extended); end
        issue(3'b010, 3'b000, 5'b00100);
        total++; if (extended !== 8'h04) begin bad++; $display("FAIL rst_jump_ext got=%h exp=04", extended); end
        issue(3'b011, 3'b111, 5'b11111);
        total++; if (extended !== 8'h00) begin bad++; $display("FAIL noimm_ext got=%h exp=00", extended); end
        total++; if (ext_valid !== 1'b1) begin bad++; $display("FAIL noimm_vld got=%b exp=1", ext_valid); end
    endtask

    initial begin
        reset = 1'b0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        opcode = '0; immediate = '0; jump_addr_short = '0;
        test_reset();
        test_basic();
        test_prefix();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid_prefix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
